// File: rtl/multicycle_control.sv
// multicycle_control
//   Multicycle control unit for the RV32 datapath. Each instruction is
//   sequenced through IF/ID/EX/MEM/WB so the combinational datapath is reused
//   across cycles. Completed instructions are counted. An unsupported encoding
//   parks the unit in HALT until reset.
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous, active-high reset
//   instr     in   [31:0] instruction at PC, stable while it executes
//   Zero      in   ALU zero flag
//   PCSrc     out  1 = PC+branch_offset, 0 = PC+4
//   ALUSrc    out  1 = immediate operand, 0 = rs2
//   RegWrite  out  register file write enable
//   MemToReg  out  1 = write back dReadData, 0 = ALU result
//   MemWrite  out  data memory write enable
//   ALUCtrl   out  [3:0] ALU operation
//   loadPC    out  PC update enable
//   state     out  [2:0] current FSM state
//   halted    out  high while parked after an illegal instruction
//   retired   out  [CNT_WIDTH-1:0] completed-instruction count (wraps)
module multicycle_control #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          instr,
    input  logic                 Zero,
    output logic                 PCSrc,
    output logic                 ALUSrc,
    output logic                 RegWrite,
    output logic                 MemToReg,
    output logic                 MemWrite,
    output logic [3:0]           ALUCtrl,
    output logic                 loadPC,
    output logic [2:0]           state,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] retired
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        K_ALU = 2'd0,
        K_LW  = 2'd1,
        K_SW  = 2'd2,
        K_BEQ = 2'd3
    } kind_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLT = 4'b0100;
    localparam logic [3:0] ALU_XOR = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;

    state_t                r_state;
    state_t                w_next;
    logic [3:0]            r_alu;
    logic                  r_src;
    kind_t                 r_kind;
    logic [CNT_WIDTH-1:0]  r_retired;

    logic [6:0]            w_opcode;
    logic [2:0]            w_f3;
    logic [6:0]            w_f7;
    logic                  w_f7_zero;
    logic                  w_f7_alt;
    logic                  w_legal;
    logic [3:0]            w_alu;
    logic                  w_src;
    kind_t                 w_kind;
    logic                  w_unused;

    assign w_opcode  = instr[6:0];
    assign w_f3      = instr[14:12];
    assign w_f7      = instr[31:25];
    assign w_f7_zero = (w_f7 == 7'b0000000);
    assign w_f7_alt  = (w_f7 == 7'b0100000);
    // Register/immediate fields are the datapath's business, not ours.
    assign w_unused  = ^{instr[24:15], instr[11:7]};

    // Instruction decode; only consulted while in ID.
    always_comb begin
        w_legal = 1'b0;
        w_alu   = ALU_AND;
        w_src   = 1'b0;
        w_kind  = K_ALU;
        unique case (w_opcode)
            7'b0110011: begin
                w_src = 1'b0;
                unique case (w_f3)
                    3'b000: begin
                        w_legal = w_f7_zero | w_f7_alt;
                        w_alu   = w_f7_alt ? ALU_SUB : ALU_ADD;
                    end
                    3'b001: begin w_legal = w_f7_zero; w_alu = ALU_SLL; end
                    3'b010: begin w_legal = w_f7_zero; w_alu = ALU_SLT; end
                    3'b100: begin w_legal = w_f7_zero; w_alu = ALU_XOR; end
                    3'b110: begin w_legal = w_f7_zero; w_alu = ALU_OR;  end
                    3'b111: begin w_legal = w_f7_zero; w_alu = ALU_AND; end
                    3'b101: begin
                        w_legal = w_f7_zero | w_f7_alt;
                        w_alu   = w_f7_alt ? ALU_SRA : ALU_SRL;
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            7'b0010011: begin
                w_src = 1'b1;
                unique case (w_f3)
                    3'b000: begin w_legal = 1'b1; w_alu = ALU_ADD; end
                    3'b010: begin w_legal = 1'b1; w_alu = ALU_SLT; end
                    3'b100: begin w_legal = 1'b1; w_alu = ALU_XOR; end
                    3'b110: begin w_legal = 1'b1; w_alu = ALU_OR;  end
                    3'b111: begin w_legal = 1'b1; w_alu = ALU_AND; end
                    3'b001: begin w_legal = w_f7_zero; w_alu = ALU_SLL; end
                    3'b101: begin
                        w_legal = w_f7_zero | w_f7_alt;
                        w_alu   = w_f7_alt ? ALU_SRA : ALU_SRL;
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            7'b0000011: begin
                w_legal = (w_f3 == 3'b010);
                w_alu   = ALU_ADD;
                w_src   = 1'b1;
                w_kind  = K_LW;
            end
            7'b0100011: begin
                w_legal = (w_f3 == 3'b010);
                w_alu   = ALU_ADD;
                w_src   = 1'b1;
                w_kind  = K_SW;
            end
            7'b1100011: begin
                w_legal = (w_f3 == 3'b000);
                w_alu   = ALU_SUB;
                w_src   = 1'b0;
                w_kind  = K_BEQ;
            end
            default: w_legal = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IF;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = S_IF;
        unique case (r_state)
            S_IF:   w_next = S_ID;
            S_ID:   w_next = w_legal ? S_EX : S_HALT;
            S_EX: begin
                unique case (r_kind)
                    K_BEQ:      w_next = S_IF;
                    K_LW, K_SW: w_next = S_MEM;
                    default:    w_next = S_WB;
                endcase
            end
            S_MEM:  w_next = (r_kind == K_SW) ? S_IF : S_WB;
            S_WB:   w_next = S_IF;
            S_HALT: w_next = S_HALT;
            default: w_next = S_IF;
        endcase
    end

    // Operation latched in ID so ALU controls stay valid through MEM/WB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu  <= '0;
            r_src  <= 1'b0;
            r_kind <= K_ALU;
        end else if (r_state == S_ID && w_legal) begin
            r_alu  <= w_alu;
            r_src  <= w_src;
            r_kind <= w_kind;
        end
    end

    // Output logic; PCSrc in EX follows Zero combinationally for BEQ.
    always_comb begin
        PCSrc    = 1'b0;
        ALUSrc   = 1'b0;
        RegWrite = 1'b0;
        MemToReg = 1'b0;
        MemWrite = 1'b0;
        ALUCtrl  = '0;
        loadPC   = 1'b0;
        unique case (r_state)
            S_EX: begin
                ALUCtrl = r_alu;
                ALUSrc  = r_src;
                if (r_kind == K_BEQ) begin
                    loadPC = 1'b1;
                    PCSrc  = Zero;
                end
            end
            S_MEM: begin
                ALUCtrl = r_alu;
                ALUSrc  = r_src;
                if (r_kind == K_SW) begin
                    MemWrite = 1'b1;
                    loadPC   = 1'b1;
                end
            end
            S_WB: begin
                ALUCtrl  = r_alu;
                ALUSrc   = r_src;
                RegWrite = 1'b1;
                loadPC   = 1'b1;
                MemToReg = (r_kind == K_LW);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retired <= '0;
        end else if (loadPC) begin
            r_retired <= r_retired + CNT_WIDTH'(1);
        end
    end

    assign state   = r_state;
    assign halted  = (r_state == S_HALT);
    assign retired = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
//   Randomized bench for multicycle_control. A reference model decodes each
//   instruction from the ISA rules, derives its cycle-by-cycle control
//   expectations and keeps its own retired count (narrow counter to exercise
//   wrap-around).
module tb_multicycle_control;

    localparam int unsigned CW = 4;

    localparam int PH_IF = 0, PH_ID = 1, PH_EX = 2, PH_MEM = 3, PH_WB = 4, PH_HALT = 5;
    localparam logic [1:0] K_ALU = 2'd0, K_LW = 2'd1, K_SW = 2'd2, K_BEQ = 2'd3;

    typedef struct packed {
        logic       legal;
        logic [3:0] alu;
        logic       src;
        logic [1:0] kind;
    } dec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   instr;
    logic          Zero;
    logic          PCSrc, ALUSrc, RegWrite, MemToReg, MemWrite, loadPC, halted;
    logic [3:0]    ALUCtrl;
    logic [2:0]    state;
    logic [CW-1:0] retired;

    int unsigned   n_checks = 0;
    int unsigned   n_errors = 0;
    logic [31:0]   exp_ret  = '0;

    multicycle_control #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .instr(instr), .Zero(Zero),
        .PCSrc(PCSrc), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .MemToReg(MemToReg),
        .MemWrite(MemWrite), .ALUCtrl(ALUCtrl), .loadPC(loadPC),
        .state(state), .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ISA-level decode of the supported subset.
    function automatic dec_t decode(input logic [31:0] ins);
        dec_t d;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        d = '0;
        if (op == 7'b0110011) begin
            d.kind = K_ALU; d.src = 1'b0;
            case (f3)
                3'b000: begin d.legal = (f7 == 7'h00 || f7 == 7'h20); d.alu = (f7 == 7'h20) ? 4'b0110 : 4'b0010; end
                3'b001: begin d.legal = (f7 == 7'h00); d.alu = 4'b1001; end
                3'b010: begin d.legal = (f7 == 7'h00); d.alu = 4'b0100; end
                3'b100: begin d.legal = (f7 == 7'h00); d.alu = 4'b0101; end
                3'b110: begin d.legal = (f7 == 7'h00); d.alu = 4'b0001; end
                3'b111: begin d.legal = (f7 == 7'h00); d.alu = 4'b0000; end
                3'b101: begin d.legal = (f7 == 7'h00 || f7 == 7'h20); d.alu = (f7 == 7'h20) ? 4'b1010 : 4'b1000; end
                default: d.legal = 1'b0;
            endcase
        end else if (op == 7'b0010011) begin
            d.kind = K_ALU; d.src = 1'b1;
            case (f3)
                3'b000: begin d.legal = 1'b1; d.alu = 4'b0010; end
                3'b010: begin d.legal = 1'b1; d.alu = 4'b0100; end
                3'b100: begin d.legal = 1'b1; d.alu = 4'b0101; end
                3'b110: begin d.legal = 1'b1; d.alu = 4'b0001; end
                3'b111: begin d.legal = 1'b1; d.alu = 4'b0000; end
                3'b001: begin d.legal = (f7 == 7'h00); d.alu = 4'b1001; end
                3'b101: begin d.legal = (f7 == 7'h00 || f7 == 7'h20); d.alu = (f7 == 7'h20) ? 4'b1010 : 4'b1000; end
                default: d.legal = 1'b0;
            endcase
        end else if (op == 7'b0000011 && f3 == 3'b010) begin
            d.legal = 1'b1; d.kind = K_LW; d.alu = 4'b0010; d.src = 1'b1;
        end else if (op == 7'b0100011 && f3 == 3'b010) begin
            d.legal = 1'b1; d.kind = K_SW; d.alu = 4'b0010; d.src = 1'b1;
        end else if (op == 7'b1100011 && f3 == 3'b000) begin
            d.legal = 1'b1; d.kind = K_BEQ; d.alu = 4'b0110; d.src = 1'b0;
        end
        return d;
    endfunction

    function automatic int cycles_of(input logic [1:0] kind);
        case (kind)
            K_BEQ:   return 3;
            K_LW:    return 5;
            default: return 4;
        endcase
    endfunction

    function automatic int phase_of(input logic [1:0] kind, input int c);
        if (c == 0) return PH_IF;
        if (c == 1) return PH_ID;
        if (c == 2) return PH_EX;
        if (c == 3) return (kind == K_LW || kind == K_SW) ? PH_MEM : PH_WB;
        return PH_WB;
    endfunction

    // Expected {state, halted, PCSrc, ALUSrc, RegWrite, MemToReg, MemWrite, loadPC, ALUCtrl}
    function automatic logic [13:0] exp_vec(input int ph, input dec_t d, input logic z);
        logic [2:0] st;
        logic h, pcs, src, rw, m2r, mw, lpc;
        logic [3:0] alu;
        st = 3'd0; h = 0; pcs = 0; src = 0; rw = 0; m2r = 0; mw = 0; lpc = 0; alu = 4'd0;
        case (ph)
            PH_ID: st = 3'd1;
            PH_EX: begin
                st = 3'd2; alu = d.alu; src = d.src;
                if (d.kind == K_BEQ) begin lpc = 1; pcs = z; end
            end
            PH_MEM: begin
                st = 3'd3; alu = d.alu; src = d.src;
                if (d.kind == K_SW) begin mw = 1; lpc = 1; end
            end
            PH_WB: begin
                st = 3'd4; alu = d.alu; src = d.src; rw = 1; lpc = 1; m2r = (d.kind == K_LW);
            end
            PH_HALT: begin st = 3'd7; h = 1; end
            default: ;
        endcase
        return {st, h, pcs, src, rw, m2r, mw, lpc, alu};
    endfunction

    function automatic logic [13:0] act_vec();
        return {state, halted, PCSrc, ALUSrc, RegWrite, MemToReg, MemWrite, loadPC, ALUCtrl};
    endfunction

    // Called at a falling edge; leaves rst low at a falling edge with DUT in IF.
    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #1;
        check({tag, "_rst_ctl"}, 32'(act_vec()), 32'(exp_vec(PH_IF, '0, 1'b0)));
        check({tag, "_rst_ret"}, 32'(retired), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_ret = '0;
    endtask

    // Runs one instruction starting at a falling edge in IF. zmode<0 drives
    // random Zero, otherwise the given value. abort_at>=0 asserts rst in that cycle.
    task automatic run_instr(input logic [31:0] ins, input int zmode, input int abort_at);
        dec_t d;
        int n;
        logic [13:0] ev;
        d = decode(ins);
        n = d.legal ? cycles_of(d.kind) : 2;
        for (int c = 0; c < n; c++) begin
            if (c == 0) instr = ins;
            Zero = (zmode < 0) ? 1'($urandom % 2) : 1'(zmode);
            #1;
            ev = exp_vec(phase_of(d.kind, c), d, Zero);
            check("ctl", 32'(act_vec()), 32'(ev));
            check("retired", 32'(retired), exp_ret);
            if (c == abort_at) begin
                pulse_reset("abort");
                return;
            end
            if (ev[4]) exp_ret = (exp_ret + 1) % (32'd1 << CW);
            @(negedge clk);
        end
        if (!d.legal) begin
            for (int k = 0; k < 20; k++) begin
                instr = $urandom;
                Zero  = 1'($urandom % 2);
                #1;
                check("halt_ctl", 32'(act_vec()), 32'(exp_vec(PH_HALT, d, Zero)));
                check("halt_ret", 32'(retired), exp_ret);
                @(negedge clk);
            end
            pulse_reset("halt");
        end
    endtask

    function automatic logic [31:0] gen_instr();
        logic [4:0] rd, rs1, rs2;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [11:0] imm;
        int sel;
        int unsigned p;
        rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom); imm = 12'($urandom);
        sel = int'($urandom % 20);
        p = $urandom % 8;
        if (sel < 5) begin
            f3 = 3'(p == 7 ? 0 : p);
            if (f3 == 3'b011) f3 = 3'b111;
            f7 = (f3 == 3'b000 || f3 == 3'b101) ? (($urandom % 2) != 0 ? 7'h20 : 7'h00) : 7'h00;
            return {f7, rs2, rs1, f3, rd, 7'b0110011};
        end else if (sel < 10) begin
            f3 = 3'(p);
            if (f3 == 3'b011) f3 = 3'b000;
            if (f3 == 3'b001) return {7'h00, rs2, rs1, f3, rd, 7'b0010011};
            if (f3 == 3'b101) return {(($urandom % 2) != 0 ? 7'h20 : 7'h00), rs2, rs1, f3, rd, 7'b0010011};
            return {imm, rs1, f3, rd, 7'b0010011};
        end else if (sel < 13) begin
            return {imm, rs1, 3'b010, rd, 7'b0000011};
        end else if (sel < 16) begin
            return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
        end else if (sel < 19) begin
            return {imm[11:5], rs2, rs1, 3'b000, imm[4:0], 7'b1100011};
        end else begin
            case (p % 4)
                0: return {7'h20, rs2, rs1, 3'b001, rd, 7'b0010011};  // SLLI with bad funct7
                1: return {imm, rs1, 3'b011, rd, 7'b0010011};         // SLTIU unsupported
                2: return {imm, rs1, 3'b000, rd, 7'b0000011};         // LB unsupported
                default: return $urandom;
            endcase
        end
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; instr = '0; Zero = 1'b0;
        @(negedge clk);
        #1;
        check("reset_ctl", 32'(act_vec()), 32'(exp_vec(PH_IF, '0, 1'b0)));
        check("reset_ret", 32'(retired), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_instr(32'h00500093, -1, -1);   // ADDI
        run_instr(32'h402081B3, -1, -1);   // SUB
        run_instr(32'h002081B3, -1, -1);   // ADD
        run_instr(32'h00812283, -1, -1);   // LW
        run_instr(32'h00512623, -1, -1);   // SW
        run_instr(32'h00208463,  1, -1);   // BEQ taken
        run_instr(32'h00208463,  0, -1);   // BEQ not taken
        run_instr(32'hFFFFFFFF, -1, -1);   // illegal -> HALT, then reset
        run_instr(32'h00812283, -1,  3);   // LW reset in MEM
        run_instr(32'h00812283, -1, -1);   // LW re-executed
        for (int i = 0; i < 18; i++) run_instr(32'h00500093, -1, -1);  // retired wraps
        for (int i = 0; i < 120; i++) run_instr(gen_instr(), -1, -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
